// File: rtl/seq_delay_checker.sv
`default_nettype none
// ============================================================================
// Module   : seq_delay_checker
// Brief    : Per-channel temporal checker for a -> b relations separated by a
//            programmable delay (exact-forward, backward, window-forward).
// Revision : 1.0 - initial release
// ============================================================================
module seq_delay_checker #(
  parameter int NCH   = 4,
  parameter int DLY_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DLY_W-1:0]     dly,
  input  logic                 clr,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  output logic [NCH-1:0]       pass,
  output logic [NCH-1:0]       fail,
  output logic [NCH-1:0]       err_sticky,
  output logic [NCH*CNT_W-1:0] fail_cnt,
  output logic                 any_err
);

  localparam int               c_dmax    = (1 << DLY_W) - 1;
  localparam logic [DLY_W-1:0] c_dmax_v  = DLY_W'(c_dmax);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [1:0]       r_mode;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] r_warm;
  logic [DLY_W-1:0] w_d;
  logic [DLY_W-1:0] w_didx;
  logic             w_restart;
  logic             w_eval;

  assign w_d       = (dly == '0) ? DLY_W'(1) : dly;
  assign w_didx    = w_d - DLY_W'(1);
  assign w_restart = en && ((mode != r_mode) || (dly != r_dly));
  assign w_eval    = en && !w_restart && (r_warm >= w_d) && (mode != 2'd3);

  // r_warm counts samples taken since the last restart, saturating at DMAX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= '0;
      r_dly  <= '0;
      r_warm <= '0;
    end else begin
      r_mode <= mode;
      r_dly  <= dly;
      if (!en)
        r_warm <= '0;
      else if (w_restart)
        r_warm <= DLY_W'(1);
      else if (r_warm != c_dmax_v)
        r_warm <= r_warm + DLY_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [c_dmax-1:0] r_hist;
      logic [DLY_W-1:0]  r_since;
      logic [CNT_W-1:0]  r_cnt;
      logic              r_pass;
      logic              r_fail;
      logic              r_sticky;
      logic              w_a_old;
      logic              w_win;
      logic              w_pass;
      logic              w_fail;

      // r_hist[k] holds a from k+1 edges ago; r_since is edges since last b
      // (DMAX means no b has occurred since the warm-up began).
      assign w_a_old = r_hist[w_didx];
      assign w_win   = b[gi] || (r_since <= w_didx);

      always_comb begin
        w_pass = 1'b0;
        w_fail = 1'b0;
        if (w_eval) begin
          case (mode)
            2'd0: if (w_a_old) begin
              w_pass = b[gi];
              w_fail = !b[gi];
            end
            2'd1: if (b[gi]) begin
              w_pass = w_a_old;
              w_fail = !w_a_old;
            end
            2'd2: if (w_a_old) begin
              w_pass = w_win;
              w_fail = !w_win;
            end
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hist   <= '0;
          r_since  <= c_dmax_v;
          r_cnt    <= '0;
          r_pass   <= 1'b0;
          r_fail   <= 1'b0;
          r_sticky <= 1'b0;
        end else begin
          r_pass <= w_pass;
          r_fail <= w_fail;
          if (!en) begin
            r_hist  <= '0;
            r_since <= c_dmax_v;
          end else if (w_restart) begin
            r_hist  <= c_dmax'(a[gi]);
            r_since <= b[gi] ? DLY_W'(1) : c_dmax_v;
          end else begin
            r_hist  <= c_dmax'({r_hist, a[gi]});
            if (b[gi])
              r_since <= DLY_W'(1);
            else if (r_since != c_dmax_v)
              r_since <= r_since + DLY_W'(1);
          end
          // Clear takes priority over a coincident fail.
          if (clr) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
          end else if (w_fail) begin
            r_sticky <= 1'b1;
            if (r_cnt != c_cnt_max)
              r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign pass[gi]                      = r_pass;
      assign fail[gi]                      = r_fail;
      assign err_sticky[gi]                = r_sticky;
      assign fail_cnt[gi*CNT_W +: CNT_W]   = r_cnt;
    end
  endgenerate

  assign any_err = |err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_seq_delay_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_delay_checker
// Brief    : Scoreboard bench for seq_delay_checker with a sample-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_delay_checker;
  localparam int NCH   = 4;
  localparam int DLY_W = 4;
  localparam int CNT_W = 3;
  localparam int DMAX  = 15;
  localparam int CMAX  = 7;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic [1:0]           mode = '0;
  logic [DLY_W-1:0]     dly = '0;
  logic                 clr = 1'b0;
  logic [NCH-1:0]       a = '0;
  logic [NCH-1:0]       b = '0;
  logic [NCH-1:0]       pass;
  logic [NCH-1:0]       fail;
  logic [NCH-1:0]       err_sticky;
  logic [NCH*CNT_W-1:0] fail_cnt;
  logic                 any_err;

  seq_delay_checker #(.NCH(NCH), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dly(dly), .clr(clr),
    .a(a), .b(b), .pass(pass), .fail(fail), .err_sticky(err_sticky),
    .fail_cnt(fail_cnt), .any_err(any_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                   edge_no;
    logic [NCH-1:0]       pass;
    logic [NCH-1:0]       fail;
    logic [NCH-1:0]       sticky;
    logic [NCH*CNT_W-1:0] cnt;
    logic                 any;
  } exp_t;

  exp_t sbq[$];
  int   edge_no  = 0;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: raw samples since warm-up start, oldest first.
  logic [NCH-1:0] ma[$];
  logic [NCH-1:0] mb[$];
  int             m_pmode = 0;
  int             m_pdly  = 0;
  logic [NCH-1:0] m_st    = '0;
  int             m_cnt[NCH];

  always @(posedge clk) edge_no++;

  task automatic model_reset();
    ma.delete();
    mb.delete();
    m_pmode = 0;
    m_pdly  = 0;
    m_st    = '0;
    for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
  endtask

  task automatic apply(input logic e, input logic [1:0] m, input logic [DLY_W-1:0] d,
                       input logic c, input logic [NCH-1:0] av, input logic [NCH-1:0] bv);
    exp_t           x;
    int             dd;
    int             n;
    logic [NCH-1:0] ep;
    logic [NCH-1:0] ef;
    logic           aold;
    logic           win;
    en = e; mode = m; dly = d; clr = c; a = av; b = bv;
    ep = '0;
    ef = '0;
    if (!e) begin
      ma.delete();
      mb.delete();
    end else begin
      if (int'(m) != m_pmode || int'(d) != m_pdly) begin
        ma.delete();
        mb.delete();
      end
      dd = (d == 0) ? 1 : int'(d);
      n  = ma.size();
      ma.push_back(av);
      mb.push_back(bv);
      if (n >= dd && m != 2'd3) begin
        for (int ch = 0; ch < NCH; ch++) begin
          aold = ma[n-dd][ch];
          win  = 1'b0;
          for (int k = n - dd + 1; k <= n; k++) win |= mb[k][ch];
          case (m)
            2'd0: if (aold) begin ep[ch] = bv[ch]; ef[ch] = !bv[ch]; end
            2'd1: if (bv[ch]) begin ep[ch] = aold; ef[ch] = !aold; end
            default: if (aold) begin ep[ch] = win; ef[ch] = !win; end
          endcase
        end
      end
      if (ma.size() > DMAX + 1) begin
        void'(ma.pop_front());
        void'(mb.pop_front());
      end
    end
    m_pmode = int'(m);
    m_pdly  = int'(d);
    for (int ch = 0; ch < NCH; ch++) begin
      if (c) begin
        m_st[ch]  = 1'b0;
        m_cnt[ch] = 0;
      end else if (ef[ch]) begin
        m_st[ch] = 1'b1;
        if (m_cnt[ch] < CMAX) m_cnt[ch]++;
      end
      x.cnt[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
    end
    x.edge_no = edge_no + 1;
    x.pass    = ep;
    x.fail    = ef;
    x.sticky  = m_st;
    x.any     = (m_st != '0);
    sbq.push_back(x);
  endtask

  task automatic run(input logic e, input logic [1:0] m, input logic [DLY_W-1:0] d,
                     input logic c, input logic [NCH-1:0] av, input logic [NCH-1:0] bv);
    @(posedge clk);
    #2;
    apply(e, m, d, c, av, bv);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pass !== '0 || fail !== '0 || err_sticky !== '0 || fail_cnt !== '0 || any_err !== 1'b0) begin
      failures++;
      $display("FAIL %s: got pass=%h fail=%h sticky=%h cnt=%h any=%b, want all zero",
               name, pass, fail, err_sticky, fail_cnt, any_err);
    end
  endtask

  // Async reset dropped mid-cycle; pending expectations are discarded.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    apply(1'b0, 2'd0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t f;
    while (sbq.size() > 0 && sbq[0].edge_no <= edge_no) begin
      f = sbq.pop_front();
      checks++;
      if (f.edge_no != edge_no) begin
        failures++;
        $display("FAIL scoreboard_order: entry for edge %0d seen at edge %0d", f.edge_no, edge_no);
      end else if (pass !== f.pass || fail !== f.fail || err_sticky !== f.sticky ||
                   fail_cnt !== f.cnt || any_err !== f.any) begin
        failures++;
        $display("FAIL edge%0d: got p=%h f=%h st=%h cnt=%h any=%b want p=%h f=%h st=%h cnt=%h any=%b",
                 edge_no, pass, fail, err_sticky, fail_cnt, any_err,
                 f.pass, f.fail, f.sticky, f.cnt, f.any);
      end
    end
  end

  initial begin
    int             pa;
    int             pb;
    int             len;
    logic [1:0]     rm;
    logic [DLY_W-1:0] rd;
    logic [NCH-1:0] ra;
    logic [NCH-1:0] rb;
    model_reset();
    #1 rst = 1'b0;
    #2 check_zero("reset_state");
    @(posedge clk);
    #2;
    rst = 1'b1;
    apply(1'b0, 2'd0, '0, 1'b0, '0, '0);

    // Mode 0, D=2: pass, then fail.
    repeat (4) run(1, 0, 2, 0, '0, '0);
    run(1, 0, 2, 0, 4'h1, '0);
    run(1, 0, 2, 0, '0, '0);
    run(1, 0, 2, 0, '0, 4'h1);
    repeat (3) run(1, 0, 2, 0, '0, '0);
    run(1, 0, 2, 0, 4'h1, '0);
    repeat (4) run(1, 0, 2, 0, '0, '0);

    // Mode 1, D=3.
    repeat (4) run(1, 1, 3, 0, '0, '0);
    run(1, 1, 3, 0, 4'h1, '0);
    repeat (2) run(1, 1, 3, 0, '0, '0);
    run(1, 1, 3, 0, '0, 4'h1);
    run(1, 1, 3, 0, '0, '0);
    run(1, 1, 3, 0, '0, 4'h1);
    repeat (6) run(1, 1, 3, 0, '0, '0);

    // Mode 2, D=4: b inside window, then b only on the trigger edge.
    repeat (3) run(1, 2, 4, 0, '0, '0);
    run(1, 2, 4, 0, 4'h1, '0);
    repeat (2) run(1, 2, 4, 0, '0, '0);
    run(1, 2, 4, 0, '0, 4'h1);
    repeat (3) run(1, 2, 4, 0, '0, '0);
    run(1, 2, 4, 0, 4'h1, 4'h1);
    repeat (6) run(1, 2, 4, 0, '0, '0);

    // Warm-up then reconfiguration.
    run(0, 1, 5, 0, '0, '0);
    repeat (9) run(1, 1, 5, 0, '0, 4'hF);
    repeat (6) run(1, 1, 2, 0, '0, 4'hF);

    // Forced fails: counter saturation, then clr coincident with a fail.
    repeat (12) run(1, 0, 1, 0, 4'hF, '0);
    run(1, 0, 1, 1, 4'hF, '0);
    run(1, 0, 1, 0, 4'h0, 4'hF);
    run(1, 0, 1, 1, 4'h0, '0);

    // Triggers pending across an async reset.
    repeat (3) run(1, 0, 5, 0, 4'hF, '0);
    mid_reset();
    repeat (10) run(1, 0, 5, 0, '0, '0);

    for (int ph = 0; ph < 40; ph++) begin
      if (ph % 10 == 5) mid_reset();
      rm  = 2'($urandom_range(0, 3));
      rd  = DLY_W'($urandom_range(0, DMAX));
      pa  = $urandom_range(1, 5);
      pb  = $urandom_range(1, 4);
      len = $urandom_range(20, 40);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 39) == 0) rd = DLY_W'($urandom_range(0, DMAX));
        if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
        for (int ch = 0; ch < NCH; ch++) begin
          ra[ch] = ($urandom_range(0, pa - 1) == 0);
          rb[ch] = ($urandom_range(0, pb - 1) == 0);
        end
        run($urandom_range(0, 19) != 0, rm, rd, $urandom_range(0, 29) == 0, ra, rb);
      end
    end

    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
